// File: rtl/ram_arb_pkg.sv
// Shared constants and types for the RAM arbiter: default widths, the MMIO
// word location, its byte-lane meaning and the response-owner encoding.
package ram_arb_pkg;

    localparam int          ADDR_W_DFLT    = 32;
    localparam int          DATA_W_DFLT    = 32;
    localparam logic [31:0] MMIO_ADDR_DFLT = 32'h0002_0000;

    localparam int CHAR_LANE = 0;
    localparam int HALT_LANE = 2;

    typedef enum logic [1:0] {
        M_NONE,
        M_IF,
        M_LSU
    } master_e;

endpackage

// File: rtl/ram_arb_mmio.sv
// Simulation MMIO word: address decode, character output register with a
// one-cycle valid pulse, and the sticky halt request with its code.
module ram_arb_mmio
    import ram_arb_pkg::*;
#(
    parameter int                ADDR_W    = ADDR_W_DFLT,
    parameter logic [ADDR_W-1:0] MMIO_ADDR = ADDR_W'(MMIO_ADDR_DFLT)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [ADDR_W-3:0] word_addr_i,
    input  logic              wr_i,
    input  logic              char_sel_i,
    input  logic              halt_sel_i,
    input  logic [7:0]        char_data_i,
    input  logic [7:0]        halt_data_i,
    output logic              hit_o,
    output logic              char_valid_o,
    output logic [7:0]        char_o,
    output logic              sim_halt_o,
    output logic [7:0]        sim_code_o
);

    logic mmio_wr;

    assign hit_o   = (word_addr_i == MMIO_ADDR[ADDR_W-1:2]);
    assign mmio_wr = wr_i && hit_o;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            char_valid_o <= 1'b0;
            char_o       <= '0;
            sim_halt_o   <= 1'b0;
            sim_code_o   <= '0;
        end else begin
            char_valid_o <= mmio_wr && char_sel_i;
            if (mmio_wr && char_sel_i) begin
                char_o <= char_data_i;
            end
            // halt is sticky; only reset clears it
            if (mmio_wr && halt_sel_i) begin
                sim_halt_o <= 1'b1;
                sim_code_o <= halt_data_i;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates the single RAM port between instruction fetch and LSU (LSU first,
// with an IF anti-starvation counter) and returns read data one cycle later.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int                ADDR_W    = ADDR_W_DFLT,
    parameter int                DATA_W    = DATA_W_DFLT,
    parameter int                MAX_WAIT  = 4,
    parameter logic [ADDR_W-1:0] MMIO_ADDR = ADDR_W'(MMIO_ADDR_DFLT)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              lsu_req_i,
    input  logic              lsu_we_i,
    input  logic [ADDR_W-1:0] lsu_addr_i,
    input  logic [3:0]        lsu_sel_i,
    input  logic [DATA_W-1:0] lsu_wdata_i,
    output logic              lsu_gnt_o,
    output logic              lsu_rvalid_o,
    output logic [DATA_W-1:0] lsu_rdata_o,
    output logic              ram_ce_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [3:0]        ram_sel_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic              char_valid_o,
    output logic [7:0]        char_o,
    output logic              sim_halt_o,
    output logic [7:0]        sim_code_o
);

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    logic              if_wait_force;
    logic              if_gnt;
    logic              lsu_gnt;
    logic              lsu_mmio;
    logic [3:0]        if_wait_q;
    master_e           owner_p1;
    logic [DATA_W-1:0] if_rdata_p1;
    logic [DATA_W-1:0] lsu_rdata_p1;

    ram_arb_mmio #(
        .ADDR_W    (ADDR_W),
        .MMIO_ADDR (MMIO_ADDR)
    ) u_mmio (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .word_addr_i  (lsu_addr_i[ADDR_W-1:2]),
        .wr_i         (lsu_gnt && lsu_we_i),
        .char_sel_i   (lsu_sel_i[CHAR_LANE]),
        .halt_sel_i   (lsu_sel_i[HALT_LANE]),
        .char_data_i  (lsu_wdata_i[7:0]),
        .halt_data_i  (lsu_wdata_i[23:16]),
        .hit_o        (lsu_mmio),
        .char_valid_o (char_valid_o),
        .char_o       (char_o),
        .sim_halt_o   (sim_halt_o),
        .sim_code_o   (sim_code_o)
    );

    // Stage p0: combinational grant and RAM drive
    always_comb begin
        if_wait_force = if_req_i && (if_wait_q == WAIT_MAX);
        lsu_gnt       = !sim_halt_o && lsu_req_i && !if_wait_force;
        if_gnt        = !sim_halt_o && if_req_i && !lsu_gnt;
    end

    assign if_gnt_o  = if_gnt;
    assign lsu_gnt_o = lsu_gnt;

    always_comb begin
        ram_ce_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_addr_o  = '0;
        ram_sel_o   = '0;
        ram_wdata_o = '0;
        if (lsu_gnt) begin
            ram_ce_o    = !lsu_mmio;
            ram_we_o    = lsu_we_i && !lsu_mmio;
            ram_addr_o  = lsu_addr_i;
            ram_sel_o   = lsu_sel_i;
            ram_wdata_o = lsu_wdata_i;
        end else if (if_gnt) begin
            ram_ce_o   = 1'b1;
            ram_addr_o = if_addr_i;
            ram_sel_o  = 4'hF;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            if_wait_q <= '0;
        end else if (if_req_i && !if_gnt) begin
            if (if_wait_q != WAIT_MAX) begin
                if_wait_q <= if_wait_q + 4'd1;
            end
        end else begin
            if_wait_q <= '0;
        end
    end

    // Stage p1: registered read response
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            owner_p1     <= M_NONE;
            if_rdata_p1  <= '0;
            lsu_rdata_p1 <= '0;
        end else begin
            owner_p1 <= M_NONE;
            if (if_gnt) begin
                owner_p1    <= M_IF;
                if_rdata_p1 <= ram_rdata_i;
            end else if (lsu_gnt && !lsu_we_i) begin
                owner_p1     <= M_LSU;
                lsu_rdata_p1 <= lsu_mmio ? '0 : ram_rdata_i;
            end
        end
    end

    assign if_rvalid_o  = (owner_p1 == M_IF);
    assign lsu_rvalid_o = (owner_p1 == M_LSU);
    assign if_rdata_o   = if_rdata_p1;
    assign lsu_rdata_o  = lsu_rdata_p1;

    // Requests must stay up until they are granted
    a_if_req_held: assert property (
        @(posedge clk_i) disable iff (!rst_n_i) (if_req_i && !if_gnt) |=> if_req_i);
    a_lsu_req_held: assert property (
        @(posedge clk_i) disable iff (!rst_n_i) (lsu_req_i && !lsu_gnt) |=> lsu_req_i);

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus random IF/LSU traffic, all
// checked every cycle against a behavioural model of the arbitration rules.
module tb_ram_arbiter;

    localparam int          MAX_WAIT = 4;
    localparam logic [31:0] MMIO     = 32'h0002_0000;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o, if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        lsu_req_i, lsu_we_i;
    logic [31:0] lsu_addr_i;
    logic [3:0]  lsu_sel_i;
    logic [31:0] lsu_wdata_i;
    logic        lsu_gnt_o, lsu_rvalid_o;
    logic [31:0] lsu_rdata_o;
    logic        ram_ce_o, ram_we_o;
    logic [31:0] ram_addr_o;
    logic [3:0]  ram_sel_o;
    logic [31:0] ram_wdata_o;
    logic [31:0] ram_rdata_i;
    logic        char_valid_o;
    logic [7:0]  char_o;
    logic        sim_halt_o;
    logic [7:0]  sim_code_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    ram_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT), .MMIO_ADDR(MMIO)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_addr_i(lsu_addr_i),
        .lsu_sel_i(lsu_sel_i), .lsu_wdata_i(lsu_wdata_i), .lsu_gnt_o(lsu_gnt_o),
        .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
        .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
        .ram_sel_o(ram_sel_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i),
        .char_valid_o(char_valid_o), .char_o(char_o),
        .sim_halt_o(sim_halt_o), .sim_code_o(sim_code_o)
    );

    function automatic logic [31:0] init_word(int i);
        return (i == 4) ? 32'h0000_0013 : (32'hA500_0000 | 32'(i));
    endfunction

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endfunction

    // Testbench RAM: 256 words, combinational read, byte-lane writes
    logic [31:0] ram [256];
    logic        ram_ready = 1'b0;

    always @(posedge clk_i) begin
        if (!ram_ready) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
            ram_ready <= 1'b1;
        end else if (ram_ce_o && ram_we_o) begin
            for (int b = 0; b < 4; b++)
                if (ram_sel_o[b]) ram[ram_addr_o[9:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
        end
    end

    assign ram_rdata_i = ram[ram_addr_o[9:2]];

    // Behavioural model and per-cycle compare
    logic [31:0] mem [256];
    logic        mem_ready = 1'b0;
    int          m_denied;
    logic        m_halt;
    logic [7:0]  m_code, m_char;
    logic        e_char_vld, e_if_vld, e_lsu_vld;
    logic [31:0] e_if_data, e_lsu_data;

    always @(negedge clk_i) begin
        int          w;   // 0 none, 1 IF, 2 LSU
        logic        lsu_mmio;
        logic [7:0]  idx;
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] = init_word(i);
            mem_ready = 1'b1;
        end
        if (!rst_n_i) begin
            m_denied = 0; m_halt = 1'b0; m_code = '0; m_char = '0;
            e_char_vld = 1'b0; e_if_vld = 1'b0; e_lsu_vld = 1'b0;
            e_if_data = '0; e_lsu_data = '0;
            chk("rst_if_gnt", if_gnt_o, 0);
            chk("rst_lsu_gnt", lsu_gnt_o, 0);
            chk("rst_rvalids", {if_rvalid_o, lsu_rvalid_o}, 0);
            chk("rst_rdata", if_rdata_o | lsu_rdata_o, 0);
            chk("rst_ram_ctl", {ram_ce_o, ram_we_o, ram_sel_o}, 0);
            chk("rst_ram_addr", ram_addr_o | ram_wdata_o, 0);
            chk("rst_mmio", {char_valid_o, sim_halt_o, char_o, sim_code_o}, 0);
        end else begin
            chk("if_rvalid", if_rvalid_o, e_if_vld);
            chk("if_rdata", if_rdata_o, e_if_data);
            chk("lsu_rvalid", lsu_rvalid_o, e_lsu_vld);
            chk("lsu_rdata", lsu_rdata_o, e_lsu_data);
            chk("char_valid", char_valid_o, e_char_vld);
            chk("char", char_o, m_char);
            chk("halt", sim_halt_o, m_halt);
            chk("halt_code", sim_code_o, m_code);

            w = 0;
            if (!m_halt) begin
                if (lsu_req_i && !(if_req_i && m_denied == MAX_WAIT)) w = 2;
                else if (if_req_i) w = 1;
            end
            lsu_mmio = (lsu_addr_i[31:2] == MMIO[31:2]);
            chk("if_gnt", if_gnt_o, (w == 1));
            chk("lsu_gnt", lsu_gnt_o, (w == 2));
            chk("ram_ce", ram_ce_o, (w == 1) || (w == 2 && !lsu_mmio));
            if (w == 0) begin
                chk("idle_ram", {ram_we_o, ram_sel_o}, 0);
                chk("idle_ram_bus", ram_addr_o | ram_wdata_o, 0);
            end else if (w == 1) begin
                chk("if_ram_addr", ram_addr_o, if_addr_i);
                chk("if_ram_we_sel", {ram_we_o, ram_sel_o}, 5'b0_1111);
            end else begin
                chk("lsu_ram_addr", ram_addr_o, lsu_addr_i);
                chk("lsu_ram_sel", ram_sel_o, lsu_sel_i);
                if (!lsu_mmio) chk("lsu_ram_we", ram_we_o, lsu_we_i);
                if (lsu_we_i) chk("lsu_ram_wdata", ram_wdata_o, lsu_wdata_i);
            end

            e_char_vld = 1'b0; e_if_vld = 1'b0; e_lsu_vld = 1'b0;
            if (w == 1) begin
                e_if_vld  = 1'b1;
                e_if_data = mem[if_addr_i[9:2]];
            end else if (w == 2) begin
                idx = lsu_addr_i[9:2];
                if (!lsu_we_i) begin
                    e_lsu_vld  = 1'b1;
                    e_lsu_data = lsu_mmio ? 32'h0 : mem[idx];
                end else if (lsu_mmio) begin
                    if (lsu_sel_i[0]) begin m_char = lsu_wdata_i[7:0]; e_char_vld = 1'b1; end
                    if (lsu_sel_i[2]) begin m_halt = 1'b1; m_code = lsu_wdata_i[23:16]; end
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (lsu_sel_i[b]) mem[idx][8*b +: 8] = lsu_wdata_i[8*b +: 8];
                end
            end
            if (if_req_i && w != 1) m_denied = (m_denied < MAX_WAIT) ? m_denied + 1 : MAX_WAIT;
            else m_denied = 0;
        end
    end

    function automatic logic [31:0] rand_word_addr();
        logic [31:0] a;
        a = 32'($urandom_range(0, 255)) << 2;
        return a;
    endfunction

    logic gi, gl;

    initial begin
        rst_n_i = 1'b0; if_req_i = 1'b0; if_addr_i = '0;
        lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_addr_i = '0; lsu_sel_i = '0; lsu_wdata_i = '0;
        repeat (3) @(posedge clk_i);
        #1 rst_n_i = 1'b1;

        // IF read of word 0x10
        @(posedge clk_i); #1;
        if_req_i = 1'b1; if_addr_i = 32'h10;
        @(negedge clk_i);
        chk("t1_if_gnt", if_gnt_o, 1);
        chk("t1_lsu_gnt", lsu_gnt_o, 0);
        @(posedge clk_i); #1;
        if_req_i = 1'b0;
        @(negedge clk_i);
        chk("t1_if_rvalid", if_rvalid_o, 1);
        chk("t1_if_rdata", if_rdata_o, 32'h0000_0013);
        chk("t1_lsu_rvalid", lsu_rvalid_o, 0);

        // LSU streams while IF waits: IF must win in cycle 4
        @(posedge clk_i); #1;
        if_req_i = 1'b1; if_addr_i = 32'h20;
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_addr_i = 32'h40; lsu_sel_i = 4'hF;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk_i);
            chk($sformatf("t2_lsu_gnt_c%0d", c), lsu_gnt_o, (c != 4));
            chk($sformatf("t2_if_gnt_c%0d", c), if_gnt_o, (c == 4));
            @(posedge clk_i); #1;
            if (c == 4) if_req_i = 1'b0;
        end
        chk("t2_wait_cleared", dut.if_wait_q, 0);

        // MMIO character write
        lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_addr_i = MMIO; lsu_sel_i = 4'b0001;
        lsu_wdata_i = 32'h41;
        @(negedge clk_i);
        chk("t3_lsu_gnt", lsu_gnt_o, 1);
        chk("t3_ram_ce", ram_ce_o, 0);
        @(posedge clk_i); #1;
        lsu_req_i = 1'b0;
        @(negedge clk_i);
        chk("t3_char_valid", char_valid_o, 1);
        chk("t3_char", char_o, 32'h41);
        @(negedge clk_i);
        chk("t3_char_valid_end", char_valid_o, 0);
        chk("t3_ram_untouched", ram[0], 32'hA500_0000);

        // Byte write then read back
        @(posedge clk_i); #1;
        lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_addr_i = 32'h100; lsu_sel_i = 4'b0010;
        lsu_wdata_i = 32'h0000_5500;
        @(negedge clk_i);
        chk("t5_ram_sel", ram_sel_o, 4'b0010);
        chk("t5_ram_ce_we", {ram_ce_o, ram_we_o}, 2'b11);
        @(posedge clk_i); #1;
        lsu_we_i = 1'b0; lsu_sel_i = 4'hF;
        @(negedge clk_i);
        chk("t5_read_gnt", lsu_gnt_o, 1);
        @(posedge clk_i); #1;
        lsu_req_i = 1'b0;
        @(negedge clk_i);
        chk("t5_rvalid", lsu_rvalid_o, 1);
        chk("t5_rdata", lsu_rdata_o, 32'hA500_5540);
        @(negedge clk_i);
        chk("t5_rvalid_end", lsu_rvalid_o, 0);
        chk("t5_rdata_hold", lsu_rdata_o, 32'hA500_5540);

        // Random traffic (no halt writes)
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk_i);
            gi = if_gnt_o; gl = lsu_gnt_o;
            @(posedge clk_i); #1;
            if (!if_req_i || gi) begin
                if_req_i  = ($urandom_range(0, 99) < 55);
                if_addr_i = ($urandom_range(0, 99) < 3) ? MMIO : rand_word_addr();
            end
            if (!lsu_req_i || gl) begin
                lsu_req_i   = ($urandom_range(0, 99) < 50);
                lsu_we_i    = 1'($urandom_range(0, 1));
                lsu_wdata_i = $urandom;
                lsu_sel_i   = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 99) < 10) begin
                    lsu_addr_i = MMIO;
                    lsu_sel_i  = lsu_sel_i & 4'b1011;
                end else begin
                    lsu_addr_i = rand_word_addr();
                end
            end
        end
        for (int n = 0; n < 20 && (if_req_i || lsu_req_i); n++) begin
            @(negedge clk_i);
            gi = if_gnt_o; gl = lsu_gnt_o;
            @(posedge clk_i); #1;
            if (gi) if_req_i = 1'b0;
            if (gl) lsu_req_i = 1'b0;
        end
        chk("drain_idle", {if_req_i, lsu_req_i}, 0);

        // Halt write, then IF is starved forever
        @(posedge clk_i); #1;
        lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_addr_i = MMIO; lsu_sel_i = 4'b0100;
        lsu_wdata_i = 32'h00AB_0000;
        @(negedge clk_i);
        chk("t4_lsu_gnt", lsu_gnt_o, 1);
        chk("t4_ram_ce", ram_ce_o, 0);
        @(posedge clk_i); #1;
        lsu_req_i = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h10;
        @(negedge clk_i);
        chk("t4_halt", sim_halt_o, 1);
        chk("t4_code", sim_code_o, 32'hAB);
        for (int n = 0; n < 4; n++) begin
            chk("t4_if_blocked", {if_gnt_o, ram_ce_o}, 0);
            @(negedge clk_i);
        end
        @(posedge clk_i); #1;
        rst_n_i = 1'b0; if_req_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        @(negedge clk_i);
        chk("t6_halt_cleared", sim_halt_o, 0);

        // Read granted, reset arrives before the response edge
        @(posedge clk_i); #1;
        if_req_i = 1'b1; if_addr_i = 32'h10;
        @(negedge clk_i);
        chk("t6_if_gnt", if_gnt_o, 1);
        #2;
        rst_n_i = 1'b0; if_req_i = 1'b0;
        @(negedge clk_i);
        chk("t6_rvalid_in_reset", if_rvalid_o, 0);
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        @(negedge clk_i);
        chk("t6_rvalid_after_reset", if_rvalid_o, 0);
        chk("t6_rdata_after_reset", if_rdata_o, 0);
        repeat (3) @(posedge clk_i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
